// File: rtl/mips_run_dump_controller_pkg.sv
// Shared defaults and state encodings for the MIPS run/dump controller.
package mips_run_dump_controller_pkg;

    localparam int unsigned DEF_N            = 32;
    localparam int unsigned DEF_ADDR_W       = 10;
    localparam int unsigned DEF_CYC_W        = 32;
    localparam int unsigned DEF_RESET_CYCLES = 2;
    localparam logic [31:0] DEF_HALT_ADDR    = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        RUN_IDLE,
        RUN_RESET,
        RUN_RUN,
        RUN_DUMP,
        RUN_DONE
    } run_state_e;

    typedef enum logic [1:0] {
        DMP_IDLE,
        DMP_RD,
        DMP_CAP,
        DMP_OUT
    } dump_state_e;

endpackage

// File: rtl/mips_run_dump_controller_mem_dump_streamer.sv
// Streams data-memory words [first, end) over valid/ready, one read-capture-offer
// round per word against a memory with one cycle of read latency.
module mem_dump_streamer
    import mips_run_dump_controller_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              go_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [N-1:0]      rd_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [N-1:0]      data_o,
    output logic              finish_c
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]      data_q, data_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= DMP_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // The exclusive end bound keeps ptr from ever wrapping.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        finish_c = 1'b0;
        case (state_q)
            DMP_IDLE: begin
                if (go_i) begin
                    ptr_d   = first_addr_i;
                    state_d = DMP_RD;
                end
            end
            DMP_RD:  state_d = DMP_CAP;
            DMP_CAP: begin
                data_d  = rd_data_i;
                state_d = DMP_OUT;
            end
            DMP_OUT: begin
                if (ready_i) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (ptr_d == end_addr_i) begin
                        finish_c = 1'b1;
                        state_d  = DMP_IDLE;
                    end else begin
                        state_d = DMP_RD;
                    end
                end
            end
        endcase
        valid_d = (state_d == DMP_OUT);
    end

    assign rd_addr_o = ptr_q;
    assign addr_o    = ptr_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/mips_run_dump_controller.sv
// Run/dump sequencer: holds the core in reset, runs it for a cycle budget or until
// a halt store, then streams a data-memory word range out.
module mips_run_dump_controller
    import mips_run_dump_controller_pkg::*;
#(
    parameter int unsigned N            = DEF_N,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned CYC_W        = DEF_CYC_W,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter logic [N-1:0] HALT_ADDR   = N'(DEF_HALT_ADDR)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] dump_start,
    input  logic [ADDR_W-1:0] dump_stop,
    output logic              core_rstb,
    input  logic              mon_wr_ena,
    input  logic [N-1:0]      mon_addr,
    input  logic [N-1:0]      mon_wr_data,
    output logic [ADDR_W-1:0] dmem_rd_addr,
    input  logic [N-1:0]      dmem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [N-1:0]      dump_data,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [N-1:0]      halt_code,
    output logic              halted,
    output logic              timeout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned RST_W = $clog2(RESET_CYCLES) + 1;

    run_state_e        state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [CYC_W-1:0]  max_q, max_d;
    logic [ADDR_W-1:0] dstart_q, dstart_d;
    logic [ADDR_W-1:0] dstop_q, dstop_d;
    logic [N-1:0]      halt_code_q, halt_code_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              core_rstb_q, core_rstb_d;
    logic              run_exit;
    logic              go_c;
    logic              dump_finish_c;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= RUN_IDLE;
            rst_cnt_q   <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            dstart_q    <= '0;
            dstop_q     <= '0;
            halt_code_q <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_rstb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            dstart_q    <= dstart_d;
            dstop_q     <= dstop_d;
            halt_code_q <= halt_code_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            core_rstb_q <= core_rstb_d;
        end
    end

    // Status outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        dstart_d    = dstart_q;
        dstop_d     = dstop_q;
        halt_code_d = halt_code_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        run_exit    = 1'b0;
        go_c        = 1'b0;
        case (state_q)
            RUN_IDLE, RUN_DONE: begin
                if (start) begin
                    max_d       = max_cycles;
                    dstart_d    = dump_start;
                    dstop_d     = dump_stop;
                    cnt_d       = '0;
                    rst_cnt_d   = '0;
                    halt_code_d = '0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = RUN_RESET;
                end
            end
            RUN_RESET: begin
                if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            RUN_RUN: begin
                // A halt store only counts while the core is actually out of reset.
                if (core_rstb_q && mon_wr_ena && (mon_addr == HALT_ADDR)) begin
                    halt_code_d = mon_wr_data;
                    halted_d    = 1'b1;
                    run_exit    = 1'b1;
                end else if (cnt_q == max_q) begin
                    timeout_d = 1'b1;
                    run_exit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
                if (run_exit) begin
                    if (dstop_q <= dstart_q) begin
                        state_d = RUN_DONE;
                    end else begin
                        go_c    = 1'b1;
                        state_d = RUN_DUMP;
                    end
                end
            end
            RUN_DUMP: begin
                if (dump_finish_c) begin
                    state_d = RUN_DONE;
                end
            end
            default: state_d = RUN_IDLE;
        endcase
        core_rstb_d = (state_d == RUN_RUN) && (cnt_d != max_d);
        busy_d      = (state_d == RUN_RESET) || (state_d == RUN_RUN) || (state_d == RUN_DUMP);
        done_d      = (state_d == RUN_DONE);
    end

    mem_dump_streamer #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_streamer (
        .clk          (clk),
        .rstb         (rstb),
        .go_i         (go_c),
        .first_addr_i (dstart_q),
        .end_addr_i   (dstop_q),
        .rd_addr_o    (dmem_rd_addr),
        .rd_data_i    (dmem_rd_data),
        .valid_o      (dump_valid),
        .ready_i      (dump_ready),
        .addr_o       (dump_addr),
        .data_o       (dump_data),
        .finish_c     (dump_finish_c)
    );

    assign core_rstb   = core_rstb_q;
    assign cycle_count = cnt_q;
    assign halt_code   = halt_code_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mips_run_dump_controller.sv
// Self-checking bench: a behavioural core/memory/consumer environment around the
// controller, directed table runs, randomized runs and multi-cycle corner sequences.
module tb_mips_run_dump_controller;

    localparam int unsigned RC        = 2;
    localparam logic [31:0] HALT_ADDR = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rstb, start;
    logic [31:0] max_cycles;
    logic [9:0]  dump_start, dump_stop;
    logic        core_rstb;
    logic        mon_wr_ena;
    logic [31:0] mon_addr, mon_wr_data;
    logic [9:0]  dmem_rd_addr;
    logic [31:0] dmem_rd_data;
    logic        dump_valid, dump_ready;
    logic [9:0]  dump_addr;
    logic [31:0] dump_data;
    logic [31:0] cycle_count, halt_code;
    logic        halted, timeout, busy, done;

    mips_run_dump_controller #(.RESET_CYCLES(RC)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .max_cycles   (max_cycles),
        .dump_start   (dump_start),
        .dump_stop    (dump_stop),
        .core_rstb    (core_rstb),
        .mon_wr_ena   (mon_wr_ena),
        .mon_addr     (mon_addr),
        .mon_wr_data  (mon_wr_data),
        .dmem_rd_addr (dmem_rd_addr),
        .dmem_rd_data (dmem_rd_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .cycle_count  (cycle_count),
        .halt_code    (halt_code),
        .halted       (halted),
        .timeout      (timeout),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [1024];
    int          en_cnt  = 0;
    int          en_base = 0;
    int          halt_at = -1;
    logic [31:0] halt_val = '0;
    int          rdy_mode = 0;
    int          rdy_ph = 0;
    int          valid_seen = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_addr;
    logic [31:0] prev_data;
    logic [41:0] dump_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Synchronous-read data memory.
    always @(posedge clk) dmem_rd_data <= mem[dmem_rd_addr];

    // Count clock edges on which the core is out of reset.
    always @(posedge clk) if (core_rstb === 1'b1) en_cnt <= en_cnt + 1;

    // Core bus activity, dump consumer and dump-stream observation.
    always @(negedge clk) begin
        if (!rstb) begin
            prev_stall = 1'b0;
            dump_ready = 1'b0;
            mon_wr_ena = 1'b0;
        end else begin
            if (core_rstb && ((en_cnt - en_base) == halt_at)) begin
                mon_wr_ena  = 1'b1;
                mon_addr    = HALT_ADDR;
                mon_wr_data = halt_val;
            end else if (!core_rstb && busy && ($urandom_range(0, 3) == 0)) begin
                mon_wr_ena  = 1'b1;
                mon_addr    = HALT_ADDR;
                mon_wr_data = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
            end else begin
                mon_wr_ena  = 1'($urandom_range(0, 1));
                mon_addr    = $urandom & 32'h0000_FFFC;
                mon_wr_data = $urandom;
            end
            case (rdy_mode)
                0: dump_ready = 1'b1;
                1: begin
                    dump_ready = (rdy_ph == 2);
                    rdy_ph = (rdy_ph + 1) % 3;
                end
                2: dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = 1'b0;
            endcase
            if (prev_stall) begin
                check("hold_valid", 64'(dump_valid), 64'd1);
                check("hold_addr", 64'(dump_addr), 64'(prev_addr));
                check("hold_data", 64'(dump_data), 64'(prev_data));
            end
            if (dump_valid) valid_seen++;
            if (dump_valid && dump_ready) dump_q.push_back({dump_addr, dump_data});
            prev_stall = dump_valid && !dump_ready;
            prev_addr  = dump_addr;
            prev_data  = dump_data;
        end
    end

    task automatic launch(input int mc, input int h_at, input logic [31:0] h_val,
                          input int ds, input int de, input int rmode);
        @(negedge clk);
        max_cycles = 32'(mc);
        dump_start = 10'(ds);
        dump_stop  = 10'(de);
        halt_at    = h_at;
        halt_val   = h_val;
        rdy_mode   = rmode;
        dump_q.delete();
        en_base    = en_cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(negedge clk);
        end
    endtask

    task automatic do_run(input int mc, input int h_at, input logic [31:0] h_val,
                          input int ds, input int de, input int rmode);
        launch(mc, h_at, h_val, ds, de, rmode);
        wait_done();
    endtask

    task automatic check_run(input string tag, input logic eh, input logic et, input int ec,
                             input logic [31:0] ecode, input int ew, input int ds);
        logic [41:0] e;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_core_rstb"}, 64'(core_rstb), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'(eh));
        check({tag, "_timeout"}, 64'(timeout), 64'(et));
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'(ec));
        check({tag, "_halt_code"}, 64'(halt_code), 64'(ecode));
        check({tag, "_core_cycles"}, 64'(en_cnt - en_base), 64'(eh ? ec + 1 : ec));
        check({tag, "_words"}, 64'(dump_q.size()), 64'(ew));
        for (int i = 0; i < dump_q.size() && i < ew; i++) begin
            e = dump_q[i];
            check($sformatf("%s_w%0d_addr", tag, i), 64'(e[41:32]), 64'(ds + i));
            check($sformatf("%s_w%0d_data", tag, i), 64'(e[31:0]), 64'(mem[ds + i]));
        end
    endtask

    typedef struct {
        int          mc;
        int          h_at;
        logic [31:0] h_val;
        int          ds;
        int          de;
        int          rmode;
        logic        eh;
        logic        et;
        int          ec;
        logic [31:0] ecode;
        int          ew;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   n, k, vs;
        int   mc, h_at, ds, de, len, ew, ec;
        logic eh;
        logic [31:0] hv;

        vecs[0] = '{200, 37, 32'h0000_00AB, 0, 0, 0, 1'b1, 1'b0, 37, 32'h0000_00AB, 0};
        vecs[1] = '{100, -1, 32'h0, 4, 8, 1, 1'b0, 1'b1, 100, 32'h0, 4};
        vecs[2] = '{0, 0, 32'h1111_1111, 5, 5, 0, 1'b0, 1'b1, 0, 32'h0, 0};
        vecs[3] = '{50, 50, 32'h2222_2222, 0, 2, 2, 1'b0, 1'b1, 50, 32'h0, 2};
        vecs[4] = '{50, 49, 32'hDEAD_BEEF, 1020, 1023, 2, 1'b1, 1'b0, 49, 32'hDEAD_BEEF, 3};
        vecs[5] = '{10, -1, 32'h0, 8, 3, 0, 1'b0, 1'b1, 10, 32'h0, 0};
        vecs[6] = '{1, 0, 32'h0000_1234, 0, 1, 1, 1'b1, 1'b0, 0, 32'h0000_1234, 1};

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rstb = 1'b0; start = 1'b0; max_cycles = '0; dump_start = '0; dump_stop = '0;
        dump_ready = 1'b0; mon_wr_ena = 1'b0; mon_addr = '0; mon_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_core_rstb", 64'(core_rstb), 64'd0);
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_halt_code", 64'(halt_code), 64'd0);
        check("rst_dump_data", 64'(dump_data), 64'd0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_core_rstb", 64'(core_rstb), 64'd0);

        // Directed table.
        for (int r = 0; r < 7; r++) begin
            do_run(vecs[r].mc, vecs[r].h_at, vecs[r].h_val, vecs[r].ds, vecs[r].de, vecs[r].rmode);
            check_run($sformatf("vec%0d", r), vecs[r].eh, vecs[r].et, vecs[r].ec,
                      vecs[r].ecode, vecs[r].ew, vecs[r].ds);
        end

        // Reset hold length, then a start pulse while busy must be ignored.
        launch(40, -1, 32'h0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_rstb) break;
            n++;
            @(negedge clk);
        end
        check("reset_hold_cycles", 64'(n), 64'(RC));
        repeat (5) @(negedge clk);
        max_cycles = 32'd3; dump_stop = 10'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_busy", 64'(busy), 64'd1);
        wait_done();
        check_run("busy_start", 1'b0, 1'b1, 40, 32'h0, 0, 0);

        // Empty range: done one cycle after the RUN exit cycle, no dump traffic.
        vs = valid_seen;
        launch(3, -1, 32'h0, 5, 5, 0);
        for (int i = 0; i < 50 && !core_rstb; i++) @(negedge clk);
        for (int i = 0; i < 50 && core_rstb; i++) @(negedge clk);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            k++;
            @(negedge clk);
        end
        check("empty_done_latency", 64'(k), 64'd1);
        check("empty_no_valid", 64'(valid_seen - vs), 64'd0);
        check_run("empty", 1'b0, 1'b1, 3, 32'h0, 0, 5);

        // Asynchronous reset while a dump word is being offered.
        launch(2, -1, 32'h0, 10, 20, 3);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dump_valid) break;
        end
        check("middump_valid_seen", 64'(dump_valid), 64'd1);
        rstb = 1'b0;
        #1;
        check("middump_valid", 64'(dump_valid), 64'd0);
        check("middump_core_rstb", 64'(core_rstb), 64'd0);
        check("middump_busy", 64'(busy), 64'd0);
        check("middump_timeout", 64'(timeout), 64'd0);
        check("middump_count", 64'(cycle_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        do_run(5, 2, 32'h0000_0C0D, 10, 12, 0);
        check_run("restart", 1'b1, 1'b0, 2, 32'h0000_0C0D, 2, 10);

        // Randomized runs against the outcome rules.
        for (int r = 0; r < 25; r++) begin
            mc   = $urandom_range(0, 60);
            h_at = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 70);
            hv   = $urandom;
            ds   = $urandom_range(0, 1023);
            len  = $urandom_range(0, 6);
            de   = (ds + len > 1023) ? 1023 : ds + len;
            if ($urandom_range(0, 7) == 0) de = $urandom_range(0, ds);
            eh   = (h_at >= 0) && (h_at < mc);
            ec   = eh ? h_at : mc;
            ew   = (de > ds) ? de - ds : 0;
            do_run(mc, h_at, hv, ds, de, $urandom_range(0, 2));
            check_run($sformatf("rnd%0d", r), eh, !eh, ec, eh ? hv : 32'h0, ew, ds);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
